// File: rtl/instr_realign_buffer.sv
// Halfword realignment FIFO between instruction fetch and decode.
// Define COMPRESSED_EN to decode 16-bit encodings; otherwise every head is 32-bit.
module instr_realign_buffer #(
    parameter int FETCH_W  = 32,
    parameter int DEPTH_HW = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic [31:0]        flush_pc,
    input  logic               fetch_valid,
    output logic               fetch_ready,
    input  logic [31:0]        fetch_pc,
    input  logic [FETCH_W-1:0] fetch_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        instr,
    output logic [31:0]        instr_pc,
    output logic               is_compressed,
    output logic               instr_illegal
);

    localparam int NHW   = FETCH_W / 16;
    localparam int OFF_W = $clog2(NHW);
    localparam int PTR_W = $clog2(DEPTH_HW);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_HW);
    localparam logic [CNT_W-1:0] NHW_C   = CNT_W'(NHW);

    logic [15:0]      r_buf [DEPTH_HW];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_pc;
    logic             r_skip_armed;
    logic [OFF_W-1:0] r_skip_off;

    logic [NHW-1:0][15:0] w_fhw;
    logic [15:0]      w_head;
    logic [15:0]      w_head_hi;
    logic             w_head_c;
    logic             w_is_c;
    logic             w_valid;
    logic             w_pop;
    logic             w_push;
    logic [CNT_W-1:0] w_need;
    logic [CNT_W-1:0] w_sub;
    logic [CNT_W-1:0] w_add;
    logic [CNT_W-1:0] w_free;
    logic [CNT_W-1:0] w_npush;
    logic [OFF_W-1:0] w_off;
    logic             w_unused;

    // Fetch PC is implied by the redirect PC plus the halfword stream.
    assign w_unused = ^{fetch_pc, flush_pc[0]};

    assign w_fhw     = fetch_data;
    assign w_head    = r_buf[r_rd_ptr];
    assign w_head_hi = r_buf[r_rd_ptr + PTR_ONE];
    assign w_head_c  = (w_head[1:0] != 2'b11);

`ifdef COMPRESSED_EN
    assign w_is_c        = w_head_c;
    assign is_compressed = w_valid & w_head_c;
    assign instr_illegal = 1'b0;
`else
    assign w_is_c        = 1'b0;
    assign is_compressed = 1'b0;
    assign instr_illegal = w_valid & w_head_c;
`endif

    assign w_need      = w_is_c ? CNT_W'(1) : CNT_W'(2);
    assign w_valid     = (r_count >= w_need);
    assign instr_valid = w_valid;
    assign instr_pc    = r_pc;

    always_comb begin
        instr = 32'h0;
        if (w_valid) begin
            if (w_is_c) instr = {16'h0, w_head};
            else        instr = {w_head_hi, w_head};
        end
    end

    assign w_pop  = w_valid & instr_ready & ~flush;
    assign w_sub  = w_pop ? w_need : '0;
    // Entries released by this cycle's consume already count as free.
    assign w_free = DEPTH_C - r_count + w_sub;
    assign fetch_ready = reset_n & ~flush & (w_free >= NHW_C);
    assign w_push = fetch_valid & fetch_ready;

    // First word after a redirect skips halfwords below the target PC.
    assign w_off   = r_skip_armed ? r_skip_off : '0;
    assign w_npush = NHW_C - {{(CNT_W-OFF_W){1'b0}}, w_off};
    assign w_add   = w_push ? w_npush : '0;

    always_ff @(posedge clk) begin
        for (int j = 0; j < NHW; j++) begin
            if (w_push && (CNT_W'(j) < w_npush))
                r_buf[r_wr_ptr + PTR_W'(j)] <= w_fhw[OFF_W'(j) + w_off];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_pc         <= 32'h0;
            r_skip_armed <= 1'b1;
            r_skip_off   <= '0;
        end else if (flush) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_pc         <= {flush_pc[31:1], 1'b0};
            r_skip_armed <= 1'b1;
            r_skip_off   <= flush_pc[OFF_W:1];
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + w_need[PTR_W-1:0];
                r_pc     <= r_pc + (w_is_c ? 32'd2 : 32'd4);
            end
            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + w_npush[PTR_W-1:0];
                r_skip_armed <= 1'b0;
            end
            r_count <= r_count + w_add - w_sub;
        end
    end

endmodule

// File: doc/instr_realign_buffer.md
INSTR_REALIGN_BUFFER -- requirements
Module: instr_realign_buffer

Interface
REQ-001 SHALL have parameter FETCH_W, default 32, fetch word width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH_HW, default 8, buffer capacity in 16-bit halfwords; power of two, at least 2*FETCH_W/16.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, discard buffer contents and redirect to flush_pc.
REQ-006 SHALL have port flush_pc, input, 32, redirect target; bit 0 ignored.
REQ-007 SHALL have port fetch_valid, input, 1, fetch word offered.
REQ-008 SHALL have port fetch_ready, output, 1, buffer accepts the fetch word this cycle.
REQ-009 SHALL have port fetch_pc, input, 32, address of the fetch word; bits [log2(FETCH_W/8)-1:0] ignored.
REQ-010 SHALL have port fetch_data, input, FETCH_W, fetch word, little-endian halfwords.
REQ-011 SHALL have port instr_valid, output, 1, complete instruction at head.
REQ-012 SHALL have port instr_ready, input, 1, consumer takes the head instruction.
REQ-013 SHALL have port instr, output, 32, aligned instruction; upper 16 bits zero when compressed.
REQ-014 SHALL have port instr_pc, output, 32, address of instr.
REQ-015 SHALL have port is_compressed, output, 1, instr is a 16-bit encoding.
REQ-016 SHALL have port instr_illegal, output, 1, 16-bit encoding seen while compression is disabled.

Function
REQ-017 Buffer SHALL be a circular halfword FIFO of DEPTH_HW entries with read pointer, write pointer and occupancy count, all wrapping modulo DEPTH_HW.
REQ-018 fetch_ready SHALL be 1 iff flush=0 and free entries >= FETCH_W/16, counting entries freed by a consume in the same cycle.
REQ-019 Fetch transfer SHALL occur when fetch_valid && fetch_ready; the entry order is halfword 0 first.
REQ-020 On the first transfer after flush or reset, halfwords below skip_pc[log2(FETCH_W/8)-1:1] SHALL be dropped, where skip_pc is the latched redirect PC; later transfers SHALL write all halfwords.
REQ-021 A head halfword with bits[1:0] != 2'b11 SHALL be a 16-bit instruction needing 1 entry; otherwise the instruction SHALL need 2 entries.
REQ-022 instr_valid SHALL be 1 iff count >= entries needed by the head; a 32-bit instruction straddling two fetch words SHALL be valid only once its upper half is written.
REQ-023 instr_valid, instr, instr_pc, is_compressed and instr_illegal SHALL be driven combinationally from registered buffer state; fetch-to-instr latency SHALL be exactly 1 cycle.
REQ-024 On consume (instr_valid && instr_ready), the read pointer and instr_pc SHALL advance by 1 entry/+2 for a compressed instruction, or by 2 entries/+4 for a 32-bit instruction.
REQ-025 While instr_ready=0, all instr outputs SHALL hold stable.
REQ-026 Flush SHALL take priority over fetch and consume in the same cycle: count:=0, pointers:=0, instr_pc:=flush_pc&~1, skip latch armed; instr_valid=0 in the following cycle.
REQ-027 A simultaneous push and pop SHALL update count by (pushed - popped) in one cycle; the count SHALL never exceed DEPTH_HW or underflow.

Reset
REQ-028 While reset_n=0: count=0, pointers=0, instr_pc=32'h0000_0000, skip latch armed, instr_valid=0, fetch_ready=0, instr=0, is_compressed=0, instr_illegal=0.
REQ-029 Reset assertion mid-operation SHALL discard all buffered halfwords immediately, without waiting for a clock edge.

Configuration
REQ-030 Macro COMPRESSED_EN defined: REQ-021 and REQ-024 SHALL apply in full, and instr_illegal SHALL be constant 0.
REQ-031 Macro COMPRESSED_EN undefined: every head SHALL be treated as 32-bit (2 entries, +4), is_compressed SHALL be constant 0, and instr_illegal SHALL equal (head[1:0] != 2'b11) when instr_valid=1.

Verification
REQ-032 Scenario: FETCH_W=32, COMPRESSED_EN defined, flush_pc=0x100, word 0x00130513 -> next cycle instr=0x00130513, instr_pc=0x100, is_compressed=0.
REQ-033 Scenario: flush_pc=0x100, word 0x4505_0505 -> instr=0x0505 @0x100 compressed, then instr=0x4505 @0x102 compressed.
REQ-034 Scenario: flush_pc=0x102, words 0x0513_xxxx then 0xxxxx_0013 -> lower halfword dropped; instr=0x00130513 @0x102 valid only after the second word is accepted.
REQ-035 Scenario: instr_ready=0 with a full buffer (DEPTH_HW=8) -> fetch_ready=0 and outputs stable; instr_ready=1 on a compressed head -> fetch_ready stays 0 until 2 entries are free.
REQ-036 Scenario: flush together with fetch_valid and instr_ready -> nothing pushed or popped, instr_valid=0 next cycle, instr_pc=flush_pc.
REQ-037 Scenario: COMPRESSED_EN undefined, word 0x4505_0505 -> instr=0x45050505, instr_illegal=1, is_compressed=0.
